inst_fetch_ctrl: RTL

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/fetch_buf.sv | 64 ++++++
 rtl/inst_fetch_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and widths for the instruction fetch controller.
//   fetch_state_t : controller state (IDLE / FETCH / HALT)
//   fetch_entry_t : one buffered instruction {data, pc}
package inst_fetch_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched instructions; slot0 is always the head.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   push, pop, flush : write new entry / retire head / discard all (flush wins)
//   wr_entry         : entry written on push
//   head             : oldest entry (valid when !empty)
//   count            : number of stored entries (0..2)
//   full, empty      : occupancy flags
module fetch_buf
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;

  assign head  = slot0;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  // Shift-register FIFO: a pop moves slot1 into slot0, a push fills the
  // first free slot as seen after that shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= wr_entry;
          else               slot1 <= wr_entry;
          count <= 2'(count + 2'd1);
        end
        2'b01: begin
          slot0 <= slot1;
          count <= 2'(count - 2'd1);
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= wr_entry;
          end else begin
            slot0 <= slot1;
            slot1 <= wr_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: walks the PC through memory, buffers fetched
// words in a 2-entry FIFO toward decode, and handles redirects and halting.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   start                  : leave IDLE and begin fetching
//   redirect, redirect_pc  : branch/jump request and target (highest priority)
//   mem_addr, mem_rdata    : instruction memory address (= PC) and read data
//   inst_valid/ready/data/pc : decode handshake and buffered instruction
//   busy, halted           : status
//   misalign_err           : sticky, set by a misaligned redirect target
//   fetch_count            : saturating count of buffered pushes
module inst_fetch_ctrl
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 8'h18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              halted,
  output logic              misalign_err,
  output logic [15:0]       fetch_count
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              push;
  logic              pop;
  logic [1:0]        count;
  logic [1:0]        cnt_nxt;
  logic              full;
  logic              empty;
  fetch_entry_t      head;

  fetch_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .wr_entry ({mem_rdata, pc}),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign mem_addr   = pc;
  assign inst_valid = !empty;
  assign inst_data  = head.data;
  assign inst_pc    = head.pc;

  // Handshake decode; a redirect suppresses both sides of the buffer.
  always_comb begin
    pop     = 1'b0;
    push    = 1'b0;
    cnt_nxt = count;
    pop  = !empty && inst_ready && !redirect;
    push = (state == FETCH) && (pc <= LAST_ADDR) && (!full || pop) && !redirect;
    unique case ({push, pop})
      2'b10:   cnt_nxt = 2'(count + 2'd1);
      2'b01:   cnt_nxt = 2'(count - 2'd1);
      default: cnt_nxt = count;
    endcase
  end

  // Controller FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      busy         <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= 16'd0;
    end else begin
      if (redirect) begin
        state  <= FETCH;
        pc     <= {redirect_pc[ADDR_W-1:2], 2'b00};
        busy   <= 1'b1;
        halted <= 1'b0;
        if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            busy <= start;
            if (start) state <= FETCH;
          end
          FETCH: begin
            if (pc > LAST_ADDR) begin
              state  <= HALT;
              halted <= 1'b1;
              busy   <= (cnt_nxt != 2'd0);
            end else begin
              busy <= 1'b1;
              if (push) pc <= ADDR_W'(pc + ADDR_W'(INST_BYTES));
            end
          end
          HALT: begin
            busy <= (cnt_nxt != 2'd0);
          end
          default: state <= IDLE;
        endcase
      end
      if (push && (fetch_count != 16'hFFFF)) fetch_count <= 16'(fetch_count + 16'd1);
    end
  end

endmodule
